// File: rtl/ifetch_pkg.sv
// Shared widths, default queue depth, fetch phase encoding and queue entry
// layout for the instruction fetch queue.
package ifetch_pkg;

  localparam int ADDR_W        = 16;
  localparam int BYTE_W        = 8;
  localparam int INSTR_W       = 16;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    HI,
    LO,
    WAIT_LO
  } phase_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Memory read port, redirect request and instruction output handshake of the
// fetch queue; master is the fetch block, slave is the memory/CPU side.
interface ifetch_queue_if;
  import ifetch_pkg::*;

  logic [ADDR_W-1:0]  mem_raddr;
  logic [BYTE_W-1:0]  mem_rdata;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output mem_raddr,
    input  mem_rdata,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_raddr,
    output mem_rdata,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/ifq_fifo.sv
// Synchronous instruction FIFO with flush and occupancy count; the head entry
// is read straight from registered storage and forced to zero when empty.
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  ifq_entry_t                 data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output ifq_entry_t                 head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ifq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign do_push = push_i && !flush_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i  && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; stale entries are never visible because the
  // head is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Byte-serial instruction fetcher: reads two bytes per instruction from a
// one-cycle-latency memory and queues {hi, lo} words, gated by queue credit.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  phase_e             phase_q, phase_d;
  logic [ADDR_W-1:0]  fpc_q, fpc_d;
  logic [BYTE_W-1:0]  hi_q, hi_d;
  logic [ADDR_W-1:0]  raddr;
  logic               push;
  logic               credit;
  logic [CNT_W-1:0]   fifo_count;
  logic [OCC_W-1:0]   occupancy;
  ifq_entry_t         push_entry;
  ifq_entry_t         head;

  // Queued entries plus the one word whose bytes are still being read.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (phase_q != HI)};
  assign credit    = (occupancy < DEPTH_OCC);

  assign push_entry.pc    = fpc_q;
  assign push_entry.instr = {hi_q, bus.mem_rdata};

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    phase_d = phase_q;
    fpc_d   = fpc_q;
    hi_d    = hi_q;
    raddr   = fpc_q;
    push    = 1'b0;
    case (phase_q)
      HI: begin
        if (credit) phase_d = LO;
      end
      LO: begin
        raddr   = fpc_q + 16'd1;
        hi_d    = bus.mem_rdata;
        phase_d = WAIT_LO;
      end
      WAIT_LO: begin
        // The next high-byte read overlaps the push of the current word.
        push    = 1'b1;
        fpc_d   = fpc_q + 16'd2;
        raddr   = fpc_q + 16'd2;
        phase_d = credit ? LO : HI;
      end
      default: phase_d = HI;
    endcase
    if (bus.redirect) begin
      fpc_d   = bus.redirect_pc;
      phase_d = HI;
      push    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= HI;
      fpc_q   <= '0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      fpc_q   <= fpc_d;
      hi_q    <= hi_d;
    end
  end

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (bus.redirect),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (bus.instr_ready),
    .valid_o (bus.instr_valid),
    .head_o  (head),
    .count_o (fifo_count)
  );

  assign bus.mem_raddr = rst ? '0 : raddr;
  assign bus.instr     = head.instr;
  assign bus.instr_pc  = head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and random-backpressure bench for ifetch_queue with a byte memory
// model and an in-order scoreboard of expected {pc, instruction} pairs.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  logic clk;
  logic rst;
  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [65536];
  ifq_entry_t sb [$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_raddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [15:0] start, input int n);
    ifq_entry_t e;
    logic [15:0] pc;
    logic [15:0] pc1;
    pc = start;
    for (int i = 0; i < n; i++) begin
      pc1     = pc + 16'd1;
      e.pc    = pc;
      e.instr = {mem[pc], mem[pc1]};
      sb.push_back(e);
      pc = pc + 16'd2;
    end
  endtask

  // One clock: score any pop about to happen, then check head stability.
  task automatic tick();
    logic        held;
    logic [15:0] h_instr;
    logic [15:0] h_pc;
    ifq_entry_t  e;
    held    = bus.instr_valid && !bus.instr_ready && !rst && !bus.redirect;
    h_instr = bus.instr;
    h_pc    = bus.instr_pc;
    if (!rst && !bus.redirect && bus.instr_valid && bus.instr_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_pc", 32'(bus.instr_pc), 32'(e.pc));
        check("pop_instr", 32'(bus.instr), 32'(e.instr));
      end
      pops++;
    end
    @(posedge clk);
    #1;
    if (held) begin
      check("hold_valid", 32'(bus.instr_valid), 32'd1);
      check("hold_instr", 32'(bus.instr), 32'(h_instr));
      check("hold_pc", 32'(bus.instr_pc), 32'(h_pc));
    end
  endtask

  initial begin
    int pops_before;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 37 + (a >> 8) + 5);
    mem[0] = 8'h81; mem[1] = 8'h23; mem[2] = 8'h91; mem[3] = 8'h45;
    mem[4] = 8'hE0; mem[5] = 8'h10; mem[6] = 8'hF0; mem[7] = 8'h01;

    rst = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.instr_ready = 1'b1;

    // Reset values and the first fetch timeline.
    repeat (2) tick();
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_pc", 32'(bus.instr_pc), 32'd0);
    check("rst_raddr", 32'(bus.mem_raddr), 32'd0);
    sb.delete();
    push_seq(16'h0000, 8);
    rst = 1'b0;
    check("c0_raddr", 32'(bus.mem_raddr), 32'h0000);
    tick();
    check("c1_raddr", 32'(bus.mem_raddr), 32'h0001);
    tick();
    check("c2_valid", 32'(bus.instr_valid), 32'd0);
    check("c2_raddr", 32'(bus.mem_raddr), 32'h0002);
    tick();
    check("c3_valid", 32'(bus.instr_valid), 32'd1);
    check("c3_instr", 32'(bus.instr), 32'h8123);
    check("c3_pc", 32'(bus.instr_pc), 32'h0000);
    repeat (2) tick();
    check("c5_valid", 32'(bus.instr_valid), 32'd1);
    check("c5_instr", 32'(bus.instr), 32'h9145);
    check("c5_pc", 32'(bus.instr_pc), 32'h0002);
    repeat (6) tick();

    // Backpressure fills the queue to its depth, then drains in order.
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    push_seq(16'h0000, 12);
    repeat (20) tick();
    check("full_valid", 32'(bus.instr_valid), 32'd1);
    check("full_instr", 32'(bus.instr), 32'h8123);
    check("full_pc", 32'(bus.instr_pc), 32'h0000);
    check("full_raddr", 32'(bus.mem_raddr), 32'h0008);
    bus.instr_ready = 1'b1;
    pops_before = pops;
    repeat (4) tick();
    check("drain_pops", 32'(pops - pops_before), 32'd4);
    check("drain_next_pc", 32'(sb[0].pc), 32'h0008);
    repeat (8) tick();

    // Redirect while the low byte of the 0x0004 word is being read.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    push_seq(16'h0000, 4);
    repeat (5) tick();
    check("lo4_raddr", 32'(bus.mem_raddr), 32'h0005);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    tick();
    bus.redirect = 1'b0;
    sb.delete();
    push_seq(16'h0040, 6);
    check("redir_valid0", 32'(bus.instr_valid), 32'd0);
    repeat (2) tick();
    check("redir_valid2", 32'(bus.instr_valid), 32'd0);
    tick();
    check("redir_valid3", 32'(bus.instr_valid), 32'd1);
    check("redir_pc3", 32'(bus.instr_pc), 32'h0040);
    repeat (8) tick();

    // Odd redirect across the top of the address space.
    mem[16'hFFFF] = 8'hAB;
    mem[0]        = 8'hCD;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    tick();
    bus.redirect = 1'b0;
    sb.delete();
    push_seq(16'hFFFF, 6);
    repeat (3) tick();
    check("wrap_valid", 32'(bus.instr_valid), 32'd1);
    check("wrap_instr", 32'(bus.instr), 32'hABCD);
    check("wrap_pc", 32'(bus.instr_pc), 32'hFFFF);
    repeat (2) tick();
    check("wrap_next_pc", 32'(bus.instr_pc), 32'h0001);
    repeat (4) tick();
    mem[0] = 8'h81;

    // Reset beats a simultaneous redirect with a full queue.
    bus.instr_ready = 1'b0;
    repeat (16) tick();
    check("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
    rst = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h1234;
    tick();
    check("rst2_valid", 32'(bus.instr_valid), 32'd0);
    check("rst2_raddr", 32'(bus.mem_raddr), 32'h0000);
    rst = 1'b0;
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    sb.delete();
    push_seq(16'h0000, 600);
    check("rst2_fpc", 32'(bus.mem_raddr), 32'h0000);
    repeat (2) tick();
    check("rst2_valid2", 32'(bus.instr_valid), 32'd0);
    tick();
    check("rst2_valid3", 32'(bus.instr_valid), 32'd1);
    check("rst2_pc3", 32'(bus.instr_pc), 32'h0000);
    check("rst2_instr3", 32'(bus.instr), 32'h8123);

    // Random consumer backpressure.
    pops_before = pops;
    for (int i = 0; i < 1000; i++) begin
      bus.instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("rand_progress", 32'(pops - pops_before > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_raddr  out  16  byte address presented to memory read port.
REQ-005 mem_rdata  in  8  byte returned by memory, valid the cycle after mem_raddr is presented.
REQ-006 redirect  in  1  CPU jump taken; flush the queue and refetch.
REQ-007 redirect_pc  in  16  new fetch byte address, sampled when redirect=1.
REQ-008 instr_valid  out  1  queue head holds an instruction.
REQ-009 instr  out  16  head instruction, {byte@pc, byte@pc+1} (big-endian).
REQ-010 instr_pc  out  16  byte address of the head instruction.
REQ-011 instr_ready  in  1  consumer accepts head; pop when instr_valid & instr_ready.

Function
REQ-012 The block SHALL hold a fetch pointer fpc and a byte phase (HI/LO).
REQ-013 In HI phase with credit, the block SHALL drive mem_raddr=fpc, then go to LO phase.
REQ-014 In LO phase, the block SHALL drive mem_raddr=fpc+1 mod 2^16, latch mem_rdata as the high byte, and go to WAIT_LO.
REQ-015 In WAIT_LO, the block SHALL push {hi, mem_rdata} with pc=fpc, set fpc=fpc+2 mod 2^16, and go to HI.
REQ-016 A new HI issue MAY overlap the WAIT_LO push; sustained throughput SHALL be one instruction per 2 cycles.
REQ-017 Credit SHALL exist only when (entries + words in flight) < DEPTH; without credit, the block SHALL stay in HI and hold mem_raddr=fpc.
REQ-018 A push and a pop in the same cycle SHALL leave the entry count unchanged.
REQ-019 Overflow and underflow SHALL be impossible by construction.
REQ-020 instr and instr_pc SHALL come from the registered head entry and stay stable while instr_valid & ~instr_ready.
REQ-021 On redirect, the queue SHALL empty, and any in-flight byte or word SHALL be discarded and never pushed.
REQ-022 On redirect, fpc SHALL load redirect_pc and the phase SHALL return to HI; the first issue at redirect_pc occurs the next cycle.
REQ-023 redirect SHALL take priority over a simultaneous pop or push.
REQ-024 instr_valid SHALL be 0 in the cycle after a redirect.
REQ-025 An odd redirect_pc SHALL be fetched as given, with no alignment; the byte at 0xFFFF followed by 0x0000 SHALL wrap.
REQ-026 The first instr_valid SHALL assert 3 cycles after the first non-reset edge, or 3 cycles after a redirect edge.

Reset
REQ-027 While rst=1, the block SHALL set fpc=0, phase=HI, queue empty, all in-flight markers cleared.
REQ-028 While rst=1, outputs SHALL be instr_valid=0, instr=0, instr_pc=0, mem_raddr=0.
REQ-029 rst SHALL override redirect and any pop/push in the same cycle.
REQ-030 A reset mid-fetch SHALL discard all partial data.

Structure
REQ-031 Package ifetch_pkg SHALL hold ADDR_W=16, BYTE_W=8, INSTR_W=16, the default DEPTH, and the phase enum {HI, LO, WAIT_LO}.
REQ-032 Queue storage and pointers SHALL live in sub-module ifq_fifo, a synchronous FIFO with push, pop, flush, count, and registered head.
REQ-033 Byte sequencing and credit SHALL live in ifetch_queue.

Verification
REQ-034 Memory with 0x00..0x07 = 81 23 91 45 E0 10 F0 01, reset, instr_ready=1 -> instr 0x8123 pc 0x0000 at cycle 3, then 0x9145 pc 2 (cycle 5), 0xE010 pc 4, 0xF001 pc 6.
REQ-035 instr_ready=0 for 20 cycles -> exactly DEPTH entries (0x0000..0x0006); mem_raddr holds 0x0008; instr stays 0x8123; on release, entries pop in order with no loss or duplicate.
REQ-036 redirect=1, redirect_pc=0x0040 while a LO fetch of 0x0004 is in flight -> instr_valid=0 next cycle; next instr_pc=0x0040 exactly 3 cycles after the redirect edge; no 0x0004 word appears.
REQ-037 redirect to 0xFFFF, mem[0xFFFF]=0xAB, mem[0x0000]=0xCD -> instr=0xABCD, instr_pc=0xFFFF; next instr_pc=0x0001.
REQ-038 rst asserted for 1 cycle with queue full and redirect=1 -> queue empty, fpc=0, mem_raddr=0; first instr_pc=0x0000 three cycles after rst deasserts.
REQ-039 Random instr_ready toggling over 1000 cycles -> the scoreboard matches sequential instructions and never sees instr change while valid & ~ready.
